// File: rtl/uart_host_pkg.sv
// uart_host_pkg
//   Shared types and constants for the UART host port: RX FSM state encoding,
//   default byte width, and the legal range of the RX FIFO read latency.
package uart_host_pkg;

  localparam int UART_BYTE_W = 8;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Wide enough to hold RD_LAT_MAX-1, the largest latency-counter load value.
  localparam int LAT_CNT_W = $clog2(RD_LAT_MAX);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_READ = 2'd1,
    RX_WAIT = 2'd2,
    RX_HOLD = 2'd3
  } rx_state_t;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/uart_host_port_hold.sv
// uart_host_hold
//   One-entry TX hold register between the host byte stream and the TX FIFO.
//   A byte loaded here is written to the FIFO as soon as the FIFO is not full.
//   The register frees itself in the same cycle it drains, so a new byte can
//   be loaded every cycle while the FIFO keeps accepting.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_i       load load_data_i this cycle (caller guarantees ready_o)
//   load_data_i  byte to load
//   drain_ok_i   TX FIFO not full
//   ready_o      register is empty or draining this cycle
//   wr_en_o      TX FIFO write strobe
//   data_o       held byte, TX FIFO write data
module uart_host_hold
  import uart_host_pkg::*;
#(
  parameter int DATA_W = UART_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              drain_ok_i,
  output logic              ready_o,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] data_o
);

  logic              hold_v_q, hold_v_d;
  logic [DATA_W-1:0] hold_d_q, hold_d_d;

  assign wr_en_o = hold_v_q && drain_ok_i;
  assign ready_o = !hold_v_q || wr_en_o;
  assign data_o  = hold_d_q;

  always_comb begin
    hold_v_d = hold_v_q;
    hold_d_d = hold_d_q;
    if (wr_en_o) begin
      hold_v_d = 1'b0;
    end
    // A load in the drain cycle wins, keeping the register full.
    if (load_i) begin
      hold_v_d = 1'b1;
      hold_d_d = load_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q <= 1'b0;
      hold_d_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_d_q <= hold_d_d;
    end
  end

endmodule

// File: rtl/uart_host_port.sv
// uart_host_port
//   Host-side controller for the UART FIFO ports. The TX path turns a
//   valid/ready byte stream into single-cycle FIFO writes through a one-entry
//   hold register; the RX path drains the RX FIFO one byte at a time into a
//   valid/ready stream toward the host. Counts FIFO writes and reads.
//   Optional feature macro: UART_HOST_ECHO_EN -- every received byte is also
//   written back to the TX path, with priority over the host.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   host -> TX byte stream
//   m_valid/m_ready/m_data   RX byte stream -> host
//   wr_en, d_in              TX FIFO write port
//   tx_can_receive_signal    TX FIFO not full
//   rd_en, d_out             RX FIFO read port (d_out valid RD_LAT cycles after rd_en)
//   rx_can_send_signal       RX FIFO not empty
//   tx_count, rx_count       wrapping counts of wr_en / rd_en pulses
//
// RX FSM
//   state   | meaning
//   RX_IDLE | waiting for the RX FIFO to become non-empty
//   RX_READ | rd_en pulse, latency counter loaded
//   RX_WAIT | counting down the FIFO read latency, capture d_out at 0
//   RX_HOLD | byte presented to the host (and echoed, when enabled)
module uart_host_port
  import uart_host_pkg::*;
#(
  parameter int DATA_W = UART_BYTE_W,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] d_in,
  input  logic              tx_can_receive_signal,
  output logic              rd_en,
  input  logic [DATA_W-1:0] d_out,
  input  logic              rx_can_send_signal,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count
);

  // Out-of-range latencies fall back to the minimum rather than building a
  // counter that cannot hold the load value.
  localparam int RD_LAT_EFF = rd_lat_legal(RD_LAT) ? RD_LAT : RD_LAT_MIN;
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT_EFF - 1);

  rx_state_t             rx_state_q, rx_state_d;
  logic [LAT_CNT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic [CNT_W-1:0]      tx_count_q, rx_count_q;

  logic                  hold_ready;
  logic                  hold_load;
  logic [DATA_W-1:0]     hold_load_data;
  logic                  echo_load;

  // ---------------------------------------------------------------- TX path

`ifdef UART_HOST_ECHO_EN
  logic echo_done_q, echo_done_d;
  logic acked_q, acked_d;

  assign echo_load = (rx_state_q == RX_HOLD) && !echo_done_q && hold_ready;
`else
  assign echo_load = 1'b0;
`endif

  // Echo takes the hold register ahead of the host.
  assign s_ready        = hold_ready && !echo_load;
  assign hold_load      = echo_load || (s_valid && s_ready);
  assign hold_load_data = echo_load ? m_data_q : s_data;

  uart_host_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .load_i      (hold_load),
    .load_data_i (hold_load_data),
    .drain_ok_i  (tx_can_receive_signal),
    .ready_o     (hold_ready),
    .wr_en_o     (wr_en),
    .data_o      (d_in)
  );

  // ---------------------------------------------------------------- RX FSM

  always_comb begin
    rx_state_d = rx_state_q;
    lat_d      = lat_q;
    m_data_d   = m_data_q;
    rd_en      = 1'b0;
    m_valid    = 1'b0;
`ifdef UART_HOST_ECHO_EN
    echo_done_d = echo_done_q;
    acked_d     = acked_q;
`endif

    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_can_send_signal) begin
          rx_state_d = RX_READ;
        end
      end

      RX_READ: begin
        rd_en      = 1'b1;
        lat_d      = LAT_LOAD;
        rx_state_d = RX_WAIT;
      end

      RX_WAIT: begin
        if (lat_q == '0) begin
          m_data_d   = d_out;
          rx_state_d = RX_HOLD;
        end else begin
          lat_d = lat_q - LAT_CNT_W'(1);
        end
      end

      RX_HOLD: begin
`ifdef UART_HOST_ECHO_EN
        // Once the host has taken the byte, stop offering it while the echo
        // is still waiting for room in the hold register.
        m_valid = !acked_q;
        if (m_valid && m_ready) begin
          acked_d = 1'b1;
        end
        if (echo_load) begin
          echo_done_d = 1'b1;
        end
        if ((acked_q || (m_valid && m_ready)) && (echo_done_q || echo_load)) begin
          acked_d     = 1'b0;
          echo_done_d = 1'b0;
          rx_state_d  = RX_IDLE;
        end
`else
        m_valid = 1'b1;
        if (m_ready) begin
          rx_state_d = RX_IDLE;
        end
`endif
      end

      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      lat_q      <= '0;
      m_data_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      lat_q      <= lat_d;
      m_data_q   <= m_data_d;
    end
  end

`ifdef UART_HOST_ECHO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_done_q <= 1'b0;
      acked_q     <= 1'b0;
    end else begin
      echo_done_q <= echo_done_d;
      acked_q     <= acked_d;
    end
  end
`endif

  assign m_data = m_data_q;

  // ---------------------------------------------------------------- counters

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      if (wr_en) begin
        tx_count_q <= tx_count_q + CNT_W'(1);
      end
      if (rd_en) begin
        rx_count_q <= rx_count_q + CNT_W'(1);
      end
    end
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;

endmodule

// File: tb/tb_uart_host_port.sv
module tb_uart_host_port;
  import uart_host_pkg::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              wr_en;
  logic [DATA_W-1:0] d_in;
  logic              tx_can;
  logic              rd_en;
  logic [DATA_W-1:0] d_out;
  logic              rx_can_send;
  logic [CNT_W-1:0]  tx_count;
  logic [CNT_W-1:0]  rx_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  uart_host_port #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .RD_LAT (RD_LAT)
  ) u_dut (
    .clk                   (clk),
    .rst                   (rst),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
    .s_data                (s_data),
    .m_valid               (m_valid),
    .m_ready               (m_ready),
    .m_data                (m_data),
    .wr_en                 (wr_en),
    .d_in                  (d_in),
    .tx_can_receive_signal (tx_can),
    .rd_en                 (rd_en),
    .d_out                 (d_out),
    .rx_can_send_signal    (rx_can_send),
    .tx_count              (tx_count),
    .rx_count              (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------ RX FIFO model + monitors
  logic [DATA_W-1:0] rx_fifo [$];
  logic [DATA_W-1:0] pipe [RD_LAT];
  logic              rd_seen = 1'b0;
  bit                mon_tx  = 1'b1;

  assign d_out = pipe[RD_LAT-1];

  always @(posedge clk) begin
    logic [DATA_W-1:0] t;
    t = 8'hEE;
    if (rd_seen && rx_fifo.size() != 0) begin
      t = rx_fifo.pop_front();
      rx_can_send = (rx_fifo.size() != 0);
    end
    pipe[0] <= t;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  logic [DATA_W-1:0] tx_obs [$];
  logic [DATA_W-1:0] tx_exp [$];
  logic [DATA_W-1:0] rx_obs [$];
  logic [DATA_W-1:0] rx_exp [$];
  int                rd_cyc [$];

  always @(negedge clk) begin
    rd_seen = rd_en;
    if (mon_tx && wr_en) tx_obs.push_back(d_in);
    if (rd_en) rd_cyc.push_back(cyc);
    if (m_valid && m_ready) rx_obs.push_back(m_data);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_data      = '0;
    m_ready     = 1'b0;
    tx_can      = 1'b1;
    rx_fifo.delete();
    rx_can_send = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_obs.delete(); tx_exp.delete();
    rx_obs.delete(); rx_exp.delete();
    rd_cyc.delete();
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; tx_can = 1'b1; rx_can_send = 1'b0; s_data = '0;
    #3;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h want=00", m_data); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
    checks++; if (d_in !== 8'h00) begin failures++; $display("FAIL reset_d_in got=%h want=00", d_in); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    checks++; if (tx_count !== 16'h0) begin failures++; $display("FAIL reset_tx_count got=%h want=0000", tx_count); end
    checks++; if (rx_count !== 16'h0) begin failures++; $display("FAIL reset_rx_count got=%h want=0000", rx_count); end
    do_reset();
  endtask

  task automatic test_tx_single();
    do_reset();
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'hA5; tx_exp.push_back(8'hA5);
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL tx1_s_ready got=%b want=1", s_ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL tx1_wr_early got=%b want=0", wr_en); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL tx1_wr_en got=%b want=1", wr_en); end
    checks++; if (d_in !== 8'hA5) begin failures++; $display("FAIL tx1_d_in got=%h want=a5", d_in); end
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL tx1_wr_single got=%b want=0", wr_en); end
    checks++; if (tx_count !== 16'd1) begin failures++; $display("FAIL tx1_count got=%0d want=1", tx_count); end
    while (tx_exp.size() != 0) begin
      logic [DATA_W-1:0] e;
      e = tx_exp.pop_front();
      checks++;
      if (tx_obs.size() == 0) begin failures++; $display("FAIL tx1_sb got=none want=%h", e); end
      else begin
        logic [DATA_W-1:0] o;
        o = tx_obs.pop_front();
        if (o !== e) begin failures++; $display("FAIL tx1_sb got=%h want=%h", o, e); end
      end
    end
    checks++; if (tx_obs.size() != 0) begin failures++; $display("FAIL tx1_extra got=%0d want=0", tx_obs.size()); end
  endtask

  task automatic test_tx_backpressure();
    do_reset();
    tx_can = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h11; tx_exp.push_back(8'h11);
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_accept_first got=%b want=1", s_ready); end
    @(posedge clk); #1;
    s_data = 8'h22; tx_exp.push_back(8'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_low got=%b want=0", s_ready); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL bp_wr_blocked got=%b want=0", wr_en); end
      @(posedge clk); #1;
    end
    tx_can = 1'b1;
    @(negedge clk);
    checks++; if (wr_en !== 1'b1 || d_in !== 8'h11) begin failures++; $display("FAIL bp_release got=%b/%h want=1/11", wr_en, d_in); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_reaccept got=%b want=1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    while (tx_exp.size() != 0) begin
      logic [DATA_W-1:0] e;
      e = tx_exp.pop_front();
      checks++;
      if (tx_obs.size() == 0) begin failures++; $display("FAIL bp_sb got=none want=%h", e); end
      else begin
        logic [DATA_W-1:0] o;
        o = tx_obs.pop_front();
        if (o !== e) begin failures++; $display("FAIL bp_sb got=%h want=%h", o, e); end
      end
    end
    checks++; if (tx_obs.size() != 0) begin failures++; $display("FAIL bp_extra got=%0d want=0", tx_obs.size()); end
    checks++; if (tx_count !== 16'd2) begin failures++; $display("FAIL bp_count got=%0d want=2", tx_count); end
  endtask

  task automatic test_rx_stream();
    int n;
    do_reset();
    m_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) begin
      rx_fifo.push_back(DATA_W'(i));
      rx_exp.push_back(DATA_W'(i));
    end
    rx_can_send = 1'b1;
    n = 0;
    while (rx_obs.size() < 3 && n < 60) begin @(negedge clk); n++; end
    checks++; if (n >= 60) begin failures++; $display("FAIL rxs_timeout got=%0d want=3 bytes", rx_obs.size()); end
    repeat (4) @(negedge clk);
    checks++; if (rd_cyc.size() != 3) begin failures++; $display("FAIL rxs_rd_pulses got=%0d want=3", rd_cyc.size()); end
    // Period is READ + RD_LAT WAIT cycles + HOLD + IDLE: RD_LAT+2 idle cycles between pulses.
    for (int i = 1; i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] - rd_cyc[i-1] != RD_LAT + 3) begin
        failures++; $display("FAIL rxs_spacing got=%0d want=%0d", rd_cyc[i] - rd_cyc[i-1], RD_LAT + 3);
      end
    end
    while (rx_exp.size() != 0) begin
      logic [DATA_W-1:0] e;
      e = rx_exp.pop_front();
      checks++;
      if (rx_obs.size() == 0) begin failures++; $display("FAIL rxs_sb got=none want=%h", e); end
      else begin
        logic [DATA_W-1:0] o;
        o = rx_obs.pop_front();
        if (o !== e) begin failures++; $display("FAIL rxs_sb got=%h want=%h", o, e); end
      end
    end
    checks++; if (rx_count !== 16'd3) begin failures++; $display("FAIL rxs_count got=%0d want=3", rx_count); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rxs_idle_valid got=%b want=0", m_valid); end
  endtask

  task automatic test_rx_backpressure();
    int n;
    int vcyc;
    do_reset();
    m_ready = 1'b0;
    @(posedge clk); #1;
    rx_fifo.push_back(8'h77); rx_fifo.push_back(8'h88);
    rx_exp.push_back(8'h77);  rx_exp.push_back(8'h88);
    rx_can_send = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 30) begin @(negedge clk); n++; end
    vcyc = cyc;
    checks++; if (n >= 30) begin failures++; $display("FAIL rxb_timeout got=no m_valid want=m_valid"); end
    checks++;
    if (rd_cyc.size() == 0 || vcyc - rd_cyc[0] != RD_LAT + 1) begin
      failures++; $display("FAIL rxb_latency got=%0d want=%0d", (rd_cyc.size() == 0) ? -1 : vcyc - rd_cyc[0], RD_LAT + 1);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h77) begin
        failures++; $display("FAIL rxb_stable got=%b/%h want=1/77", m_valid, m_data);
      end
    end
    checks++; if (rd_cyc.size() != 1) begin failures++; $display("FAIL rxb_single_rd got=%0d want=1", rd_cyc.size()); end
    @(posedge clk); #1;
    m_ready = 1'b1;
    n = 0;
    while (rx_obs.size() < 2 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n >= 40) begin failures++; $display("FAIL rxb_drain_timeout got=%0d want=2 bytes", rx_obs.size()); end
    while (rx_exp.size() != 0) begin
      logic [DATA_W-1:0] e;
      e = rx_exp.pop_front();
      checks++;
      if (rx_obs.size() == 0) begin failures++; $display("FAIL rxb_sb got=none want=%h", e); end
      else begin
        logic [DATA_W-1:0] o;
        o = rx_obs.pop_front();
        if (o !== e) begin failures++; $display("FAIL rxb_sb got=%h want=%h", o, e); end
      end
    end
    checks++; if (rx_count !== 16'd2) begin failures++; $display("FAIL rxb_count got=%0d want=2", rx_count); end
  endtask

  task automatic test_rollover();
    do_reset();
    mon_tx = 1'b0;
    tx_can = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h5C;
    repeat (65535) @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_count !== 16'hFFFF) begin failures++; $display("FAIL roll_preload got=%h want=ffff", tx_count); end
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'hC5;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_count !== 16'h0000) begin failures++; $display("FAIL roll_wrap got=%h want=0000", tx_count); end
    mon_tx = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    int rd_before;
    do_reset();
    tx_can  = 1'b1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h3C;
    rx_fifo.push_back(8'h99);
    rx_can_send = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rd_en && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin failures++; $display("FAIL rstm_no_rd got=no rd_en want=rd_en"); end
    @(posedge clk); #2;
    checks++; if (u_dut.rx_state_q !== RX_WAIT) begin failures++; $display("FAIL rstm_pre_state got=%0d want=%0d", u_dut.rx_state_q, RX_WAIT); end
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL rstm_pre_wr got=%b want=1", wr_en); end
    rst = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rstm_wr_en got=%b want=0", wr_en); end
    checks++; if (rd_en !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL rstm_rx got=%b/%b want=0/0", rd_en, m_valid); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rstm_s_ready got=%b want=1", s_ready); end
    checks++; if (u_dut.rx_state_q !== RX_IDLE) begin failures++; $display("FAIL rstm_state got=%0d want=%0d", u_dut.rx_state_q, RX_IDLE); end
    checks++; if (tx_count !== 16'h0 || rx_count !== 16'h0) begin failures++; $display("FAIL rstm_counts got=%h/%h want=0/0", tx_count, rx_count); end
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_before = rd_cyc.size();
    repeat (6) @(negedge clk);
    checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin failures++; $display("FAIL rstm_discard got=%b/%h want=0/00", m_valid, m_data); end
    checks++; if (rd_cyc.size() != rd_before) begin failures++; $display("FAIL rstm_no_reread got=%0d want=%0d", rd_cyc.size(), rd_before); end
  endtask

`ifdef UART_HOST_ECHO_EN
  task automatic test_echo();
    int n;
    do_reset();
    tx_can  = 1'b1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    rx_fifo.push_back(8'h5A);
    rx_exp.push_back(8'h5A);
    rx_can_send = 1'b1;
    n = 0;
    while (!m_valid && n < 30) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 30) begin failures++; $display("FAIL echo_timeout got=no m_valid want=m_valid"); end
    s_valid = 1'b1; s_data = 8'h33;
    tx_exp.push_back(8'h5A); tx_exp.push_back(8'h33);
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL echo_priority got=%b want=0", s_ready); end
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (rx_obs.size() < 1 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    while (tx_exp.size() != 0) begin
      logic [DATA_W-1:0] e;
      e = tx_exp.pop_front();
      checks++;
      if (tx_obs.size() == 0) begin failures++; $display("FAIL echo_tx_sb got=none want=%h", e); end
      else begin
        logic [DATA_W-1:0] o;
        o = tx_obs.pop_front();
        if (o !== e) begin failures++; $display("FAIL echo_tx_sb got=%h want=%h", o, e); end
      end
    end
    while (rx_exp.size() != 0) begin
      logic [DATA_W-1:0] e;
      e = rx_exp.pop_front();
      checks++;
      if (rx_obs.size() == 0) begin failures++; $display("FAIL echo_rx_sb got=none want=%h", e); end
      else begin
        logic [DATA_W-1:0] o;
        o = rx_obs.pop_front();
        if (o !== e) begin failures++; $display("FAIL echo_rx_sb got=%h want=%h", o, e); end
      end
    end
    checks++; if (rx_obs.size() != 0) begin failures++; $display("FAIL echo_rx_extra got=%0d want=0", rx_obs.size()); end
    checks++; if (tx_count !== 16'd2) begin failures++; $display("FAIL echo_tx_count got=%0d want=2", tx_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'hEE;
    test_reset();
    test_tx_single();
    test_tx_backpressure();
    test_rx_stream();
    test_rx_backpressure();
    test_reset_mid();
`ifdef UART_HOST_ECHO_EN
    test_echo();
`endif
    test_rollover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
